// File: rtl/placar_entrada_pontos.sv
// Button conditioning and score holding for a two-team scoreboard: synchronise and debounce
// the 1/2/3-point buttons, turn each press into one scoring event, and keep both scores within limits.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for a debounced rising edge on any point button
// APPLY        | applying the latched weight/sign/team to the selected score
// WAIT_RELEASE | one event per press: hold until every button is released
module placar_entrada_pontos #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_SCORE       = 99,
  parameter int ALERT_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       ChaveNegativaPositiva,
  input  logic       MudarTime,
  output logic [1:0] SaidaBtns,
  output logic [6:0] pontos0,
  output logic [6:0] pontos1,
  output logic       commit,
  output logic       buzzer,
  output logic       led
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(ALERT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, APPLY, WAIT_RELEASE} state_t;

  state_t state_q, state_d;

  logic [2:0]    raw, sync1, sync2, deb, deb_q;
  logic [DW-1:0] dcnt [3];
  logic [BW-1:0] buzz_cnt;
  logic          sub_q, team_q;

  logic          press, one_hot, latch_en, fire, wr;
  logic [1:0]    weight;
  logic [6:0]    sel_score, new_score;
  logic [7:0]    sum;

  assign raw = {C, B, A};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  // The counter only runs while the synchronised level disagrees with the accepted one.
  for (genvar i = 0; i < 3; i++) begin : g_deb
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt[i] <= '0;
        deb[i]  <= 1'b0;
      end else if (sync2[i] == deb[i]) begin
        dcnt[i] <= '0;
      end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        dcnt[i] <= '0;
        deb[i]  <= sync2[i];
      end else begin
        dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end

  assign press   = |(deb & ~deb_q);
  assign one_hot = (deb == 3'b001) || (deb == 3'b010) || (deb == 3'b100);

  always_comb begin
    case (deb)
      3'b001:  weight = 2'd1;
      3'b010:  weight = 2'd2;
      3'b100:  weight = 2'd3;
      default: weight = 2'd0;
    endcase
  end

  assign sel_score = team_q ? pontos1 : pontos0;
  assign sum       = {1'b0, sel_score} + {6'b0, SaidaBtns};

  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    fire      = 1'b0;
    wr        = 1'b0;
    new_score = sel_score;
    case (state_q)
      IDLE: begin
        if (press) begin
          if (one_hot) begin
            latch_en = 1'b1;
            state_d  = APPLY;
          end else begin
            fire    = 1'b1;
            state_d = WAIT_RELEASE;
          end
        end
      end
      APPLY: begin
        state_d = WAIT_RELEASE;
        if (!sub_q) begin
          if (sum <= 8'(MAX_SCORE)) begin
            wr        = 1'b1;
            new_score = sum[6:0];
          end else begin
            fire = 1'b1;
          end
        end else if ({5'b0, SaidaBtns} <= sel_score) begin
          wr        = 1'b1;
          new_score = sel_score - {5'b0, SaidaBtns};
        end else begin
          fire = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (deb == 3'b000) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      SaidaBtns <= '0;
      sub_q     <= 1'b0;
      team_q    <= 1'b0;
      pontos0   <= '0;
      pontos1   <= '0;
      commit    <= 1'b0;
      buzz_cnt  <= '0;
      led       <= 1'b0;
    end else begin
      state_q <= state_d;
      commit  <= wr;
      led     <= (pontos0 == 7'(MAX_SCORE)) || (pontos1 == 7'(MAX_SCORE));
      if (latch_en) begin
        SaidaBtns <= weight;
        sub_q     <= ChaveNegativaPositiva;
        team_q    <= MudarTime;
      end
      if (wr) begin
        if (team_q) pontos1 <= new_score;
        else        pontos0 <= new_score;
      end
      // A re-fire reloads rather than extends the pulse.
      if (fire)                buzz_cnt <= BW'(ALERT_CYCLES);
      else if (buzz_cnt != '0) buzz_cnt <= buzz_cnt - 1'b1;
    end
  end

  assign buzzer = (buzz_cnt != '0);

endmodule

// File: tb/tb_placar_entrada_pontos.sv
// Directed bench for placar_entrada_pontos: a table of single presses with hand-computed
// results, plus hand-written sequences for timing, bounce, limits, team latching and reset.
module tb_placar_entrada_pontos;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A = 1'b0, B = 1'b0, C = 1'b0;
  logic       ChaveNegativaPositiva = 1'b0;
  logic       MudarTime = 1'b0;
  logic [1:0] SaidaBtns;
  logic [6:0] pontos0, pontos1;
  logic       commit, buzzer, led;

  int n_cmp = 0;
  int n_err = 0;
  int commit_cnt = 0;
  int buzz_cnt = 0;

  placar_entrada_pontos #(
    .DEBOUNCE_CYCLES(4),
    .MAX_SCORE(99),
    .ALERT_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .C(C),
    .ChaveNegativaPositiva(ChaveNegativaPositiva),
    .MudarTime(MudarTime),
    .SaidaBtns(SaidaBtns),
    .pontos0(pontos0),
    .pontos1(pontos1),
    .commit(commit),
    .buzzer(buzzer),
    .led(led)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (commit) commit_cnt++;
      if (buzzer) buzz_cnt++;
    end
  end

  typedef struct {
    logic [2:0] btn;   // {C,B,A}
    logic       sub;
    logic       team;
    int         p0;
    int         p1;
    int         saida;
    int         commits;
    int         buzz;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [2:0] btn, input logic sub, input logic team);
    @(negedge clk);
    ChaveNegativaPositiva = sub;
    MudarTime = team;
    {C, B, A} = btn;
    repeat (14) @(negedge clk);
    {C, B, A} = 3'b000;
    repeat (14) @(negedge clk);
  endtask

  initial begin
    int first;
    bit seen;

    tbl[0] = '{3'b100, 1'b1, 1'b0, 2, 0, 3, 0, 3};  // C sub: 3 > 2, rejected
    tbl[1] = '{3'b010, 1'b1, 1'b0, 0, 0, 2, 1, 0};  // B sub: 2 - 2 = 0
    tbl[2] = '{3'b001, 1'b1, 1'b0, 0, 0, 1, 0, 3};  // A sub at 0: rejected
    tbl[3] = '{3'b100, 1'b0, 1'b1, 0, 3, 3, 1, 0};  // C add team1
    tbl[4] = '{3'b101, 1'b0, 1'b0, 0, 3, 3, 0, 3};  // A+C: invalid
    tbl[5] = '{3'b010, 1'b0, 1'b1, 0, 5, 2, 1, 0};  // B add team1
    tbl[6] = '{3'b111, 1'b0, 1'b0, 0, 5, 2, 0, 3};  // A+B+C: invalid
    tbl[7] = '{3'b001, 1'b1, 1'b1, 0, 4, 1, 1, 0};  // A sub team1

    #12;
    chk("rst_pontos0", pontos0, 0);
    chk("rst_pontos1", pontos1, 0);
    chk("rst_saida", SaidaBtns, 0);
    chk("rst_commit", commit, 0);
    chk("rst_buzzer", buzzer, 0);
    chk("rst_led", led, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean B press: commit exactly 8 edges after the raw rise.
    commit_cnt = 0;
    first = -1;
    seen = 0;
    B = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (commit && !seen) begin
        first = i;
        seen = 1;
      end
    end
    chk("b_commit_edge", first, 8);
    chk("b_saida", SaidaBtns, 2);
    chk("b_pontos0", pontos0, 2);
    chk("b_pontos1", pontos1, 0);
    @(negedge clk);
    B = 1'b0;
    repeat (14) @(negedge clk);
    chk("b_commit_count", commit_cnt, 1);

    foreach (tbl[k]) begin
      commit_cnt = 0;
      buzz_cnt = 0;
      press(tbl[k].btn, tbl[k].sub, tbl[k].team);
      chk($sformatf("v%0d_pontos0", k), pontos0, tbl[k].p0);
      chk($sformatf("v%0d_pontos1", k), pontos1, tbl[k].p1);
      chk($sformatf("v%0d_saida", k), SaidaBtns, tbl[k].saida);
      chk($sformatf("v%0d_commits", k), commit_cnt, tbl[k].commits);
      chk($sformatf("v%0d_buzz", k), buzz_cnt, tbl[k].buzz);
    end

    // Bouncing A press and release: exactly one event.
    commit_cnt = 0;
    @(negedge clk);
    ChaveNegativaPositiva = 1'b0;
    MudarTime = 1'b0;
    A = 1'b1; @(negedge clk);
    A = 1'b0; @(negedge clk);
    A = 1'b1;
    repeat (14) @(negedge clk);
    A = 1'b0; @(negedge clk);
    A = 1'b1; @(negedge clk);
    A = 1'b0;
    repeat (14) @(negedge clk);
    chk("bounce_commits", commit_cnt, 1);
    chk("bounce_pontos0", pontos0, 1);

    // Bring team 1 from 4 to 98.
    for (int i = 0; i < 31; i++) press(3'b100, 1'b0, 1'b1);
    press(3'b001, 1'b0, 1'b1);
    chk("load_pontos1", pontos1, 98);
    chk("load_led", led, 0);

    // 98 + 3 overflows: rejected, buzzer exactly 3 cycles.
    commit_cnt = 0;
    buzz_cnt = 0;
    press(3'b100, 1'b0, 1'b1);
    chk("ovf_pontos1", pontos1, 98);
    chk("ovf_commits", commit_cnt, 0);
    chk("ovf_buzz", buzz_cnt, 3);

    // 98 + 1 reaches the limit; led follows one cycle after the commit.
    @(negedge clk);
    MudarTime = 1'b1;
    A = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (commit) seen = 1;
    end
    chk("max_commit_seen", seen, 1);
    chk("max_pontos1", pontos1, 99);
    chk("max_led_same_cycle", led, 0);
    @(posedge clk);
    #1;
    chk("max_led_next_cycle", led, 1);
    @(negedge clk);
    A = 1'b0;
    repeat (14) @(negedge clk);

    // A+C together, then C held alone: no event until both are released.
    commit_cnt = 0;
    buzz_cnt = 0;
    MudarTime = 1'b0;
    A = 1'b1;
    C = 1'b1;
    repeat (14) @(negedge clk);
    A = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_c_commits", commit_cnt, 0);
    chk("hold_c_buzz", buzz_cnt, 3);
    C = 1'b0;
    repeat (14) @(negedge clk);
    chk("hold_c_saida", SaidaBtns, 1);
    chk("hold_c_pontos0", pontos0, 1);
    chk("hold_c_commits_after", commit_cnt, 0);

    // MudarTime toggled during APPLY: update lands on team 0.
    commit_cnt = 0;
    B = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    MudarTime = 1'b1;
    repeat (14) @(negedge clk);
    B = 1'b0;
    repeat (14) @(negedge clk);
    chk("team_latch_pontos0", pontos0, 3);
    chk("team_latch_pontos1", pontos1, 99);
    chk("team_latch_commits", commit_cnt, 1);

    // Reset during APPLY discards the event.
    MudarTime = 1'b0;
    A = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pontos0", pontos0, 0);
    chk("mid_rst_pontos1", pontos1, 0);
    chk("mid_rst_saida", SaidaBtns, 0);
    chk("mid_rst_commit", commit, 0);
    chk("mid_rst_buzzer", buzzer, 0);
    chk("mid_rst_led", led, 0);
    @(negedge clk);
    A = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    commit_cnt = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_commits", commit_cnt, 0);
    chk("post_rst_pontos0", pontos0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
